// File: rtl/rx_integrate_dump.sv
// rx_integrate_dump: integrate-and-dump receiver stage behind the channel model.
// Drops SKIP guard samples at the start of each symbol window, integrates the
// rest with a saturating accumulator and issues a hard sign decision plus the
// integrated metric when the window closes.
//
// Optional build macro: RX_ERASE_EN adds the 'erase' low-confidence output.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for ch_valid; the first high edge takes sample 0
// ACCUM    | counting samples, integrating those at index >= SKIP
// DECIDE   | one cycle; decision/short_err pulse is visible on the outputs
// WAIT_LOW | window closed on SPS samples, strobe still high; wait for 0
module rx_integrate_dump #(
    parameter int SPS    = 10,
    parameter int SKIP   = 2,
    parameter int ACC_W  = 18,
    parameter int THRESH = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ch_valid,
    input  logic signed [13:0]      ch_in,
    output logic                    bit_out,
    output logic signed [ACC_W-1:0] sum_out,
    output logic                    bit_valid,
    output logic                    short_err
`ifdef RX_ERASE_EN
    ,
    output logic                    erase
`endif
);

    localparam int CNT_W = $clog2(SPS + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCUM    = 2'd1;
    localparam logic [1:0] ST_DECIDE   = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW = 2'd3;

    localparam logic [CNT_W-1:0] SPS_C  = CNT_W'(SPS);
    localparam logic [CNT_W-1:0] SKIP_C = CNT_W'(SKIP);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Reject parameter sets the datapath cannot honour (guard must leave at
    // least one sample, accumulator must hold a full input sample).
    if (SPS < 1 || SKIP < 0 || SKIP >= SPS || ACC_W < 14 || THRESH < 0) begin : g_cfg_check
        $error("rx_integrate_dump: illegal parameter set");
    end

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    integ_q, integ_d;
    logic                    bit_out_q, bit_out_d;
    logic signed [ACC_W-1:0] sum_out_q, sum_out_d;
    logic                    bit_valid_q, bit_valid_d;
    logic                    short_err_q, short_err_d;
    logic                    close;

`ifdef RX_ERASE_EN
    localparam logic [ACC_W:0] THRESH_C = (ACC_W+1)'(THRESH);
    logic           erase_q, erase_d;
    logic [ACC_W:0] acc_mag;
`endif

    // Add one sign-extended sample, clamping to the accumulator range so a
    // saturated window keeps re-clamping instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [13:0]      s
    );
        logic signed [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {{(ACC_W-13){s[13]}}, s};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return sum[ACC_W-1:0];
    endfunction

    // Next-state, counting and integration; decision outputs are loaded on
    // the edge that closes the window so they are visible during DECIDE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        integ_d     = integ_q;
        bit_out_d   = bit_out_q;
        sum_out_d   = sum_out_q;
        bit_valid_d = 1'b0;
        short_err_d = 1'b0;
        close       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ch_valid) begin
                    cnt_d   = ONE_C;
                    acc_d   = '0;
                    integ_d = 1'b0;
                    if (SKIP_C == '0) begin
                        acc_d   = sat_add('0, ch_in);
                        integ_d = 1'b1;
                    end
                    if (SPS_C == ONE_C) begin
                        state_d = ST_DECIDE;
                        close   = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (!ch_valid) begin
                    state_d = ST_DECIDE;
                    close   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q >= SKIP_C) begin
                        acc_d   = sat_add(acc_q, ch_in);
                        integ_d = 1'b1;
                    end
                    if (cnt_d == SPS_C) begin
                        state_d = ST_DECIDE;
                        close   = 1'b1;
                    end
                end
            end
            ST_DECIDE: begin
                state_d = ch_valid ? ST_WAIT_LOW : ST_IDLE;
            end
            ST_WAIT_LOW: begin
                if (!ch_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (close) begin
            if (integ_d) begin
                bit_valid_d = 1'b1;
                bit_out_d   = ~acc_d[ACC_W-1];
                sum_out_d   = acc_d;
            end else begin
                short_err_d = 1'b1;
            end
        end
    end

`ifdef RX_ERASE_EN
    // Magnitude in one extra bit so the most negative value maps to max+1.
    // erase only moves with an actual decision; a short window leaves it.
    always_comb begin
        acc_mag = {acc_d[ACC_W-1], acc_d};
        if (acc_d[ACC_W-1]) begin
            acc_mag = (ACC_W+1)'(0) - {acc_d[ACC_W-1], acc_d};
        end
        erase_d = erase_q;
        if (close && integ_d) begin
            erase_d = (acc_mag < THRESH_C);
        end
    end

    // Erase flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            erase_q <= 1'b0;
        end else begin
            erase_q <= erase_d;
        end
    end

    assign erase = erase_q;
`endif

    // State, accumulator and registered outputs; reset drops any partial window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            integ_q     <= 1'b0;
            bit_out_q   <= 1'b0;
            sum_out_q   <= '0;
            bit_valid_q <= 1'b0;
            short_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            integ_q     <= integ_d;
            bit_out_q   <= bit_out_d;
            sum_out_q   <= sum_out_d;
            bit_valid_q <= bit_valid_d;
            short_err_q <= short_err_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign sum_out   = sum_out_q;
    assign bit_valid = bit_valid_q;
    assign short_err = short_err_q;

endmodule

// File: tb/tb_rx_integrate_dump.sv
// Scoreboard bench for rx_integrate_dump: d0 uses default parameters, d1 uses
// ACC_W=16 for the saturation cases. Stimulus pushes expected decisions, a
// single monitor process pops and compares whenever a pulse appears.
module tb_rx_integrate_dump;

    localparam int SPS = 10;

    typedef struct {
        bit is_short;
        bit exp_bit;
        int exp_sum;
        int exp_cyc;
        bit chk_erase;
        bit exp_erase;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic               cv0 = 1'b0;
    logic               cv1 = 1'b0;
    logic signed [13:0] ci0 = '0;
    logic signed [13:0] ci1 = '0;

    logic               bo0, bv0, se0;
    logic signed [17:0] so0;
    logic               bo1, bv1, se1;
    logic signed [15:0] so1;
    logic               er0v, er1v;

    exp_t sb0 [64];
    exp_t sb1 [64];
    int   wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;

    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;
    bit   done   = 1'b0;
    bit   prev0  = 1'b0;
    bit   prev1  = 1'b0;

`ifdef RX_ERASE_EN
    logic er0, er1;
    assign er0v = er0;
    assign er1v = er1;
`else
    assign er0v = 1'b0;
    assign er1v = 1'b0;
`endif

    rx_integrate_dump d0 (
        .clk       (clk),
        .reset     (reset),
        .ch_valid  (cv0),
        .ch_in     (ci0),
        .bit_out   (bo0),
        .sum_out   (so0),
        .bit_valid (bv0),
        .short_err (se0)
`ifdef RX_ERASE_EN
        ,
        .erase     (er0)
`endif
    );

    rx_integrate_dump #(.ACC_W(16)) d1 (
        .clk       (clk),
        .reset     (reset),
        .ch_valid  (cv1),
        .ch_in     (ci1),
        .bit_out   (bo1),
        .sum_out   (so1),
        .bit_valid (bv1),
        .short_err (se1)
`ifdef RX_ERASE_EN
        ,
        .erase     (er1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push(input int sel, input bit s, input bit b, input int sum,
                        input bit ce, input bit ee);
        exp_t e;
        e.is_short  = s;
        e.exp_bit   = b;
        e.exp_sum   = sum;
        e.exp_cyc   = cyc + 1;
        e.chk_erase = ce;
        e.exp_erase = ee;
        if (sel == 0) begin sb0[wr0 % 64] = e; wr0++; end
        else          begin sb1[wr1 % 64] = e; wr1++; end
    endtask

    task automatic drive(input int sel, input logic v, input int x);
        if (sel == 0) begin cv0 = v; ci0 = 14'(x); end
        else          begin cv1 = v; ci1 = 14'(x); end
        @(negedge clk);
    endtask

    // n high samples of value x, then low; expectation is pushed just before
    // the edge that closes the window (SPS-th sample or first low).
    task automatic window(input int sel, input int n, input int x, input bit s,
                          input bit b, input int sum, input bit ce, input bit ee);
        for (int i = 0; i < n; i++) begin
            if (i == SPS - 1) push(sel, s, b, sum, ce, ee);
            drive(sel, 1'b1, x);
        end
        if (n < SPS) begin
            push(sel, s, b, sum, ce, ee);
            drive(sel, 1'b0, 0);
        end
        drive(sel, 1'b0, 0);
    endtask

    task automatic score(input int sel, input logic bv, input logic se, input logic bo,
                         input int so, input logic er, input bit prev);
        exp_t e;
        bit   have;
        chk($sformatf("d%0d_pulse_exclusive", sel), int'(bv && se), 0);
        chk($sformatf("d%0d_pulse_width", sel), int'(prev), 0);
        have = 1'b0;
        if (sel == 0 && rd0 != wr0) begin e = sb0[rd0 % 64]; rd0++; have = 1'b1; end
        if (sel == 1 && rd1 != wr1) begin e = sb1[rd1 % 64]; rd1++; have = 1'b1; end
        if (!have) begin
            chk($sformatf("d%0d_unexpected_pulse", sel), 1, 0);
        end else begin
            chk($sformatf("d%0d_short_err", sel), int'(se), int'(e.is_short));
            chk($sformatf("d%0d_bit_out", sel), int'(bo), int'(e.exp_bit));
            chk($sformatf("d%0d_sum_out", sel), so, e.exp_sum);
            chk($sformatf("d%0d_pulse_cycle", sel), cyc, e.exp_cyc);
            if (e.chk_erase) chk($sformatf("d%0d_erase", sel), int'(er), int'(e.exp_erase));
        end
    endtask

    // Monitor: reset values (including right after a mid-cycle reset), then
    // scoreboard pops on every pulse, drain check and summary at the end.
    always begin
        @(negedge clk or negedge reset);
        #1;
        if (!reset) begin
            chk("rst_d0_bit_out", int'(bo0), 0);
            chk("rst_d0_sum_out", int'(so0), 0);
            chk("rst_d0_bit_valid", int'(bv0), 0);
            chk("rst_d0_short_err", int'(se0), 0);
            chk("rst_d0_erase", int'(er0v), 0);
            chk("rst_d1_bit_out", int'(bo1), 0);
            chk("rst_d1_sum_out", int'(so1), 0);
            chk("rst_d1_bit_valid", int'(bv1), 0);
            chk("rst_d1_short_err", int'(se1), 0);
            prev0 = 1'b0;
            prev1 = 1'b0;
        end else begin
            if (bv0 || se0) score(0, bv0, se0, bo0, int'(so0), er0v, prev0);
            if (bv1 || se1) score(1, bv1, se1, bo1, int'(so1), er1v, prev1);
            prev0 = bv0 || se0;
            prev1 = bv1 || se1;
            if (done) begin
                chk("d0_scoreboard_drained", wr0 - rd0, 0);
                chk("d1_scoreboard_drained", wr1 - rd1, 0);
                $display("%0d/%0d checks passed", passed, total);
                $finish;
            end
            if (cyc > 3000) begin
                chk("watchdog_cycle_budget", cyc, 3000);
                $display("%0d/%0d checks passed", passed, total);
                $finish;
            end
        end
    end

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 16; w++) begin
            if (w % 2 == 0) window(0, 10, 500, 1'b0, 1'b1, 4000, 1'b0, 1'b0);
            else            window(0, 10, -300, 1'b0, 1'b0, -2400, 1'b0, 1'b0);
        end

        // Guard-only window: short_err, outputs keep the previous decision.
        window(0, 2, 1234, 1'b1, 1'b0, -2400, 1'b0, 1'b0);
        // Zero sum ties to a 1 decision.
        window(0, 10, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        // Strobe-terminated window: indices 2..4 integrated, 3*7.
        window(0, 5, 7, 1'b0, 1'b1, 21, 1'b0, 1'b0);
        // Strobe held for 15: single decision after sample 10, then wait for low.
        window(0, 15, 100, 1'b0, 1'b1, 800, 1'b0, 1'b0);

        // ACC_W=16 saturation both ways.
        window(1, 10, 8191, 1'b0, 1'b1, 32767, 1'b0, 1'b0);
        window(1, 10, -8192, 1'b0, 1'b0, -32768, 1'b0, 1'b0);

        // Reset in the middle of a window: no pulse, outputs cleared at once.
        for (int i = 0; i < 5; i++) drive(0, 1'b1, 1000);
        #2 reset = 1'b0;
        cv0 = 1'b0;
        ci0 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        window(0, 10, -50, 1'b0, 1'b0, -400, 1'b0, 1'b0);

`ifdef RX_ERASE_EN
        window(0, 10, 20, 1'b0, 1'b1, 160, 1'b1, 1'b1);
        window(0, 10, 40, 1'b0, 1'b1, 320, 1'b1, 1'b0);
`endif

        repeat (3) drive(0, 1'b0, 0);
        done = 1'b1;
    end

endmodule
